// File: rtl/sdram_rd_checker_if.sv
// Read-data return path from the SDRAM controller into the pattern checker.
// The master side is the controller (or a bench standing in for it).
interface sdram_rd_checker_if;
    logic        rd_ack;
    logic        rd_vld;
    logic [15:0] rd_data;

    modport master (
        output rd_ack,
        output rd_vld,
        output rd_data
    );

    modport slave (
        input rd_ack,
        input rd_vld,
        input rd_data
    );
endinterface

// File: rtl/sdram_rd_checker.sv
// Checks a returned SDRAM read burst against an incrementing 16-bit pattern and
// reports pass/fail, error count, first mismatch and idle timeout.
module sdram_rd_checker #(
    parameter int unsigned BURST_LEN = 255,
    parameter logic [15:0] SEED      = 16'd1,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    sdram_rd_checker_if.slave        rd,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic                     timeout,
    output logic [8:0]               err_cnt,
    output logic [8:0]               first_err_idx,
    output logic [15:0]              first_err_data
);

    typedef enum logic [1:0] {StIdle, StArmed, StRecv, StDone} state_e;

    localparam logic [8:0] LastIdx   = 9'(BURST_LEN - 1);
    localparam logic [9:0] IdleLimit = 10'(TIMEOUT - 1);

    state_e      state;
    logic [15:0] exp_data;
    logic [8:0]  word_cnt;
    logic [9:0]  idle_cnt;

    logic       active;
    logic       take_word;
    logic       mismatch;
    logic       last_word;
    logic       idle_expire;
    logic [8:0] err_cnt_inc;

    always_comb begin
        active      = (state == StArmed) || (state == StRecv);
        // A word that arrives together with rd_ack is the first word of the burst.
        take_word   = rd.rd_vld && ((state == StRecv) || (state == StArmed && rd.rd_ack));
        mismatch    = take_word && (rd.rd_data != exp_data);
        last_word   = take_word && (word_cnt == LastIdx);
        idle_expire = active && !rd.rd_vld && (idle_cnt == IdleLimit);
        err_cnt_inc = (err_cnt == 9'd511) ? err_cnt : err_cnt + 9'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= StIdle;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_cnt        <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            exp_data       <= '0;
            word_cnt       <= '0;
            idle_cnt       <= '0;
        end else if (start) begin
            // Arms from any state; an in-flight test is abandoned and its word dropped.
            state          <= StArmed;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_cnt        <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            exp_data       <= SEED;
            word_cnt       <= '0;
            idle_cnt       <= '0;
        end else begin
            unique case (state)
                StArmed, StRecv: begin
                    if (state == StArmed && rd.rd_ack) begin
                        state <= StRecv;
                    end
                    idle_cnt <= rd.rd_vld ? 10'd0 : idle_cnt + 10'd1;

                    if (take_word) begin
                        exp_data <= exp_data + 16'd1;
                        word_cnt <= word_cnt + 9'd1;
                        if (mismatch) begin
                            err_cnt <= err_cnt_inc;
                            if (err_cnt == 9'd0) begin
                                first_err_idx  <= word_cnt;
                                first_err_data <= rd.rd_data;
                            end
                        end
                        if (last_word) begin
                            state <= StDone;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= !mismatch && (err_cnt == 9'd0);
                        end
                    end else if (idle_expire) begin
                        state   <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        timeout <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
